spmv_gather_pipe: RTL and testbench
===================================

Name: spmv_gather_pipe

Overview:
- Consumer end of the SpMV scatter update stream.
- Accepts (update_value, update_dest) pairs and accumulates each value into a local vertex-attribute buffer.
- Buffer has one entry per destination vertex of the current interval; accumulation is read-modify-write.
- On command, streams the accumulated attributes out in address order, clearing each entry as it is read, so the next phase starts from zero.

Parameters:
- URAM_DATA_W, 32: width of accumulated attribute and of update_value.
- ADDR_W, 10: log2 of buffer depth (vertices per interval).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- update_value  in  URAM_DATA_W  update to add.
- update_dest  in  32  destination vertex index.
- input_valid  in  1  update present this cycle.
- input_ready  out  1  block can accept an update this cycle.
- drain_start  in  1  single-cycle pulse requesting readout.
- out_attr  out  URAM_DATA_W  accumulated attribute.
- out_addr  out  ADDR_W  vertex index of out_attr.
- out_valid  out  1  out_attr/out_addr valid.
- out_ready  in  1  downstream accepts the output word.
- drain_done  out  1  one-cycle pulse after the last word is accepted.
- err_cnt  out  16  count of out-of-range updates; saturates at 0xFFFF.

Behaviour:
- Reset (rst=0 at a clock edge): all outputs go to 0, the FSM enters CLEAR, and the pipeline is flushed. Reset taken mid-DRAIN or mid-ACCUM abandons the operation; no drain_done is produced.
- Accepted update: input_valid && input_ready.
  - When input_ready=0, input_valid is ignored: no buffer change, no err_cnt change.
- Range check: an update is out of range if update_dest[31:ADDR_W] != 0.
  - Out-of-range updates are dropped and err_cnt increments by 1 (saturating).
  - Otherwise index = update_dest[ADDR_W-1:0].
- Arithmetic: unsigned add modulo 2^URAM_DATA_W, with no saturation and no overflow flag.
- FSM states:
  - CLEAR:
    - input_ready=0.
    - Writes 0 to addresses 0..2^ADDR_W-1, one per cycle.
    - After the last address, enters ACCUM.
    - drain_start is ignored.
  - ACCUM:
    - input_ready=1; one update per cycle may be accepted.
    - Update commit latency is 3 cycles from acceptance.
    - Back-to-back or interleaved updates to the same index must give exactly the sequential sum; in-flight results are forwarded, so there are no stalls and no lost updates.
    - On drain_start=1, enters DRAIN.
    - An update accepted in the same cycle as drain_start is included in the drain.
  - DRAIN:
    - input_ready=0.
    - Waits until the accumulation pipeline is empty, then presents addresses 0..2^ADDR_W-1 in order.
    - out_valid is registered.
    - While out_valid=1 and out_ready=0, out_attr and out_addr hold stable.
    - On each handshake, the entry is written to 0 and the next address is presented. The first word may follow the previous handshake by at most 1 cycle.
    - After the last handshake: out_valid=0, drain_done=1 for one cycle, then ACCUM.
    - drain_start is ignored.
- err_cnt is not cleared by drain; it is cleared only by reset.
- Throughput:
  - ACCUM: 1 update per cycle, sustained.
  - DRAIN with out_ready held 1: 1 word per cycle after at most 4 cycles of startup.

Test Plan (ADDR_W=4):
- Reset: hold rst=0 for 3 cycles, then release.
  - Required: all outputs 0; input_ready rises exactly 16 cycles after rst=1.
  - Then drain with out_ready=1: 16 words, all out_attr=0, out_addr=0..15, drain_done pulses once.
- Single update: value=20, dest=8, then drain.
  - Required: out_addr=8 gives out_attr=20; all other addresses 0.
  - A second immediate drain returns all 0, which verifies read-and-clear.
- Same-destination hazard: 5 consecutive updates to dest=3 with values 1,2,3,4,5, then drain.
  - Required: addr 3 = 15.
  - Repeat the pattern 3,5,3,5,3 with value 10 each: required addr3=30, addr5=20.
- Out-of-range and wrap:
  - dest=16 value=7, then dest=0xFFFFFFFF value=7: required err_cnt=2, all entries 0.
  - dest=2 value=0xFFFFFFFF, then dest=2 value=2: required addr2=1.
- Backpressure: drain with out_ready toggling 1,0,0,1,...
  - Required: no word lost or duplicated; out_attr/out_addr stable while stalled.
  - Updates presented during DRAIN are ignored.
  - drain_start issued during CLEAR or DRAIN has no effect.
- Reset mid-drain: assert rst=0 after 5 words have been accepted.
  - Required: out_valid=0 next cycle and no drain_done; after the 16-cycle CLEAR, a new drain reads all 0.

Source files
------------

// File: rtl/spmv_gather_pipe_if.sv
// Signal bundle for the SpMV gather block: the incoming update stream, the
// outgoing drain stream, and the drain/error status signals.
interface spmv_gather_pipe_if #(
  parameter int URAM_DATA_W = 32,
  parameter int ADDR_W      = 10
);
  logic [URAM_DATA_W-1:0] update_value;
  logic [31:0]            update_dest;
  logic                   input_valid;
  logic                   input_ready;
  logic                   drain_start;
  logic [URAM_DATA_W-1:0] out_attr;
  logic [ADDR_W-1:0]      out_addr;
  logic                   out_valid;
  logic                   out_ready;
  logic                   drain_done;
  logic [15:0]            err_cnt;

  modport master (
    output update_value, update_dest, input_valid, drain_start, out_ready,
    input  input_ready, out_attr, out_addr, out_valid, drain_done, err_cnt
  );

  modport slave (
    input  update_value, update_dest, input_valid, drain_start, out_ready,
    output input_ready, out_attr, out_addr, out_valid, drain_done, err_cnt
  );
endinterface

// File: rtl/spmv_gather_pipe.sv
// SpMV gather stage: accumulates scatter updates into a per-interval vertex
// buffer and drains it in address order, clearing each entry as it is read.
module spmv_gather_pipe #(
  parameter int URAM_DATA_W = 32,
  parameter int ADDR_W      = 10
) (
  input  logic               clk,
  input  logic               rst,
  spmv_gather_pipe_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_CLEAR, S_ACCUM, S_DRAIN} state_e;

  state_e state_q, state_d;

  logic [URAM_DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]      clr_addr_q, clr_addr_d;
  logic [ADDR_W:0]        ptr_q, ptr_d;

  logic                   vld_p0_q, vld_p1_q, vld_p2_q, vld_p3_q;
  logic [ADDR_W-1:0]      idx_p0_q, idx_p1_q, idx_p2_q, idx_p3_q;
  logic [URAM_DATA_W-1:0] val_p0_q, val_p1_q, rd_p1_q, sum_p2_q, sum_p3_q;

  logic [URAM_DATA_W-1:0] out_attr_q;
  logic [ADDR_W-1:0]      out_addr_q;
  logic                   out_valid_q, drain_done_q;
  logic [15:0]            err_cnt_q;

  logic                   accept, in_range, pipe_busy, hs, load, clearing;
  logic [ADDR_W-1:0]      raddr;
  logic [URAM_DATA_W-1:0] base_p1, sum_p1;
  logic                   we;
  logic [ADDR_W-1:0]      waddr;
  logic [URAM_DATA_W-1:0] wdata;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [URAM_DATA_W-1:0] wrap_add(input logic [URAM_DATA_W-1:0] a,
                                                      input logic [URAM_DATA_W-1:0] b);
    return a + b;
  endfunction

  assign in_range  = (bus.update_dest >> ADDR_W) == 32'd0;
  assign accept    = bus.input_valid && bus.input_ready;
  assign pipe_busy = vld_p0_q | vld_p1_q | vld_p2_q;
  assign hs        = out_valid_q && bus.out_ready;
  // One shared read port: an in-flight update read takes priority over the drain pointer.
  assign raddr     = vld_p0_q ? idx_p0_q : ptr_q[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_CLEAR;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: if (clr_addr_q == {ADDR_W{1'b1}}) state_d = S_ACCUM;
      S_ACCUM: if (bus.drain_start) state_d = S_DRAIN;
      S_DRAIN: if (hs && ptr_q[ADDR_W]) state_d = S_ACCUM;
      default: state_d = S_CLEAR;
    endcase
  end

  always_comb begin
    bus.input_ready = (state_q == S_ACCUM);
    clearing        = (state_q == S_CLEAR);
    load            = (state_q == S_DRAIN) && !pipe_busy && !ptr_q[ADDR_W] &&
                      (!out_valid_q || bus.out_ready);
    clr_addr_d      = clearing ? clr_addr_q + ADDR_W'(1) : '0;
    ptr_d           = (state_q != S_DRAIN) ? '0 :
                      load ? ptr_q + (ADDR_W+1)'(1) : ptr_q;
  end

  // Forward results still in flight that the p1 read could not observe.
  always_comb begin
    base_p1 = rd_p1_q;
    if (vld_p2_q && idx_p2_q == idx_p1_q)      base_p1 = sum_p2_q;
    else if (vld_p3_q && idx_p3_q == idx_p1_q) base_p1 = sum_p3_q;
    sum_p1 = wrap_add(base_p1, val_p1_q);
  end

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (clearing) begin
      we    = 1'b1;
      waddr = clr_addr_q;
    end else if (hs) begin
      we    = 1'b1;
      waddr = out_addr_q;
    end else if (vld_p2_q) begin
      we    = 1'b1;
      waddr = idx_p2_q;
      wdata = sum_p2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      clr_addr_q   <= '0;
      ptr_q        <= '0;
      vld_p0_q     <= 1'b0;
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      vld_p3_q     <= 1'b0;
      out_attr_q   <= '0;
      out_addr_q   <= '0;
      out_valid_q  <= 1'b0;
      drain_done_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      clr_addr_q   <= clr_addr_d;
      ptr_q        <= ptr_d;
      vld_p0_q     <= accept && in_range;
      vld_p1_q     <= vld_p0_q;
      vld_p2_q     <= vld_p1_q;
      vld_p3_q     <= vld_p2_q;
      if (accept && !in_range) err_cnt_q <= sat_inc(err_cnt_q);
      if (load) begin
        out_attr_q <= mem_q[raddr];
        out_addr_q <= ptr_q[ADDR_W-1:0];
      end
      out_valid_q  <= load | (out_valid_q & ~hs);
      drain_done_q <= hs & ptr_q[ADDR_W];
    end
  end

  always_ff @(posedge clk) begin
    // p0: accepted update
    idx_p0_q <= bus.update_dest[ADDR_W-1:0];
    val_p0_q <= bus.update_value;
    // p1: buffer read
    idx_p1_q <= idx_p0_q;
    val_p1_q <= val_p0_q;
    rd_p1_q  <= mem_q[raddr];
    // p2: summed, written next edge; p3: last written, kept for forwarding
    idx_p2_q <= idx_p1_q;
    sum_p2_q <= sum_p1;
    idx_p3_q <= idx_p2_q;
    sum_p3_q <= sum_p2_q;
    if (we) mem_q[waddr] <= wdata;
  end

  assign bus.out_attr   = out_attr_q;
  assign bus.out_addr   = out_addr_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.drain_done = drain_done_q;
  assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_spmv_gather_pipe.sv
// Directed bench for spmv_gather_pipe with a 16-entry buffer: clear, accumulate
// hazards, range/wrap, backpressure and reset during drain.
module tb_spmv_gather_pipe;
  localparam int W  = 32;
  localparam int AW = 4;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spmv_gather_pipe_if #(.URAM_DATA_W(W), .ADDR_W(AW)) bus_if ();

  spmv_gather_pipe #(.URAM_DATA_W(W), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_v [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    bus_if.input_valid  = 1'b0;
    bus_if.update_value = '0;
    bus_if.update_dest  = '0;
    bus_if.drain_start  = 1'b0;
    bus_if.out_ready    = 1'b1;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < N; i++) exp_v[i] = '0;
  endtask

  task automatic send(input logic [31:0] val, input logic [31:0] dest);
    bus_if.input_valid  = 1'b1;
    bus_if.update_value = val;
    bus_if.update_dest  = dest;
    @(negedge clk);
    bus_if.input_valid  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus_if.out_valid), 32'd0);
    chk({tag, "_done"},  32'(bus_if.drain_done), 32'd0);
    chk({tag, "_err"},   32'(bus_if.err_cnt), 32'd0);
    chk({tag, "_attr"},  bus_if.out_attr, 32'd0);
    chk({tag, "_addr"},  32'(bus_if.out_addr), 32'd0);
    chk({tag, "_ready"}, 32'(bus_if.input_ready), 32'd0);
  endtask

  // Counts cycles from reset release to input_ready while poking inputs that CLEAR must ignore.
  task automatic wait_ready(input string tag);
    int n;
    int dd;
    n = 0;
    dd = 0;
    bus_if.input_valid  = 1'b1;
    bus_if.update_value = 32'd99;
    bus_if.update_dest  = 32'd1;
    while (!bus_if.input_ready && n < 64) begin
      bus_if.drain_start = (n == 3);
      @(negedge clk);
      n++;
      if (bus_if.drain_done) dd++;
    end
    idle();
    chk({tag, "_ready_cycles"}, 32'(n), 32'd16);
    chk({tag, "_no_done"}, 32'(dd), 32'd0);
  endtask

  task automatic run_drain(input string tag, input bit start, input bit stall, input bit spam);
    int got;
    int cyc;
    bit stalled;
    logic [31:0]   h_attr;
    logic [AW-1:0] h_addr;
    if (start) begin
      bus_if.drain_start = 1'b1;
      @(negedge clk);
      bus_if.drain_start = 1'b0;
    end
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    h_attr = '0;
    h_addr = '0;
    while (got < N && cyc < 300) begin
      if (stalled) begin
        chk({tag, "_stall_attr"}, bus_if.out_attr, h_attr);
        chk({tag, "_stall_addr"}, 32'(bus_if.out_addr), 32'(h_addr));
      end
      bus_if.out_ready = stall ? (cyc % 3 == 0) : 1'b1;
      if (spam) begin
        bus_if.input_valid  = (got < 12);
        bus_if.update_dest  = cyc[0] ? 32'd7 : 32'h100;
        bus_if.update_value = 32'd100;
        bus_if.drain_start  = (cyc == 6);
      end
      stalled = bus_if.out_valid && !bus_if.out_ready;
      h_attr  = bus_if.out_attr;
      h_addr  = bus_if.out_addr;
      if (bus_if.out_valid && bus_if.out_ready) begin
        chk({tag, "_addr"}, 32'(bus_if.out_addr), 32'(got[AW-1:0]));
        chk({tag, "_attr"}, bus_if.out_attr, exp_v[got]);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    idle();
    chk({tag, "_words"}, 32'(got), 32'(N));
    chk({tag, "_done_pulse"}, 32'(bus_if.drain_done), 32'd1);
    chk({tag, "_valid_off"}, 32'(bus_if.out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_done_oneshot"}, 32'(bus_if.drain_done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int cyc;
    idle();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b1;
    wait_ready("rst");
    clear_exp();
    run_drain("zero", 1'b1, 1'b0, 1'b0);

    send(32'd20, 32'd8);
    clear_exp();
    exp_v[8] = 32'd20;
    run_drain("single", 1'b1, 1'b0, 1'b0);
    clear_exp();
    run_drain("reclear", 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      bus_if.input_valid  = 1'b1;
      bus_if.update_value = 32'(i + 1);
      bus_if.update_dest  = 32'd3;
      @(negedge clk);
    end
    bus_if.input_valid = 1'b0;
    clear_exp();
    exp_v[3] = 32'd15;
    run_drain("same3", 1'b1, 1'b0, 1'b0);

    // Last update shares its cycle with drain_start and must still be drained.
    for (int i = 0; i < 5; i++) begin
      bus_if.input_valid  = 1'b1;
      bus_if.update_value = 32'd10;
      bus_if.update_dest  = i[0] ? 32'd5 : 32'd3;
      bus_if.drain_start  = (i == 4);
      @(negedge clk);
    end
    idle();
    clear_exp();
    exp_v[3] = 32'd30;
    exp_v[5] = 32'd20;
    run_drain("interleave", 1'b0, 1'b0, 1'b0);

    send(32'd7, 32'd16);
    send(32'd7, 32'hFFFF_FFFF);
    chk("oor_err", 32'(bus_if.err_cnt), 32'd2);
    send(32'hFFFF_FFFF, 32'd2);
    send(32'd2, 32'd2);
    clear_exp();
    exp_v[2] = 32'd1;
    run_drain("wrap", 1'b1, 1'b0, 1'b0);
    chk("err_kept", 32'(bus_if.err_cnt), 32'd2);

    clear_exp();
    for (int i = 0; i < N; i++) begin
      exp_v[i] = 32'(i * 3 + 1);
      send(32'(i * 3 + 1), 32'(i));
    end
    run_drain("bp", 1'b1, 1'b1, 1'b1);
    clear_exp();
    run_drain("after_bp", 1'b1, 1'b0, 1'b0);
    chk("err_after_bp", 32'(bus_if.err_cnt), 32'd2);

    send(32'd9, 32'd4);
    bus_if.drain_start = 1'b1;
    @(negedge clk);
    bus_if.drain_start = 1'b0;
    got = 0;
    cyc = 0;
    while (got < 5 && cyc < 100) begin
      if (bus_if.out_valid) got++;
      @(negedge clk);
      cyc++;
    end
    chk("mid_words", 32'(got), 32'd5);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_valid", 32'(bus_if.out_valid), 32'd0);
    chk("mid_done", 32'(bus_if.drain_done), 32'd0);
    chk("mid_err", 32'(bus_if.err_cnt), 32'd0);
    chk("mid_ready", 32'(bus_if.input_ready), 32'd0);
    rst = 1'b1;
    wait_ready("mid");
    clear_exp();
    run_drain("mid_zero", 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
